// File: rtl/exp_golomb_pkg.sv
// Purpose : shared types and helpers for the order-k Exp-Golomb decoder slice.
// Latency : n/a (types, constants and a combinational mapping function).
// Backpr. : n/a.
package exp_golomb_pkg;

    typedef enum logic [1:0] {
        PREFIX = 2'd0,
        SUFFIX = 2'd1,
        OUT    = 2'd2
    } state_e;

    // Working width of ue_to_se; callers keep the low DATA_WIDTH bits.
    localparam int MAP_W = 64;

    // Bits needed to count prefix zeros and suffix bits (both stay below DATA_WIDTH).
    function automatic int cnt_width(input int dw);
        return $clog2(dw);
    endfunction

    // Signed mapping: odd n -> positive (n+1)/2, even n -> -(n/2).
    function automatic logic [MAP_W-1:0] ue_to_se(input logic [MAP_W-1:0] n);
        if (n[0]) begin
            return (n + MAP_W'(1)) >> 1;
        end
        return -(n >> 1);
    endfunction

endpackage

// File: rtl/exp_golomb_k_decoder_if.sv
// Purpose : serial-bit input and decoded-value output handshakes of the decoder.
// Latency : n/a (wiring only).
// Backpr. : ready_o throttles dt_i/valid_i; ready_i throttles dt_o/err_o/valid_o.
// Ports   : dt_i/valid_i/ready_o bit side; dt_o/err_o/valid_o/ready_i value side.
interface exp_golomb_k_decoder_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  dt_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] dt_o;
    logic                  err_o;
    logic                  valid_o;
    logic                  ready_i;

    modport slave (
        input  dt_i, valid_i, ready_i,
        output ready_o, dt_o, err_o, valid_o
    );

    modport master (
        output dt_i, valid_i, ready_i,
        input  ready_o, dt_o, err_o, valid_o
    );
endinterface

// File: rtl/exp_golomb_map.sv
// Purpose : turn the accumulated codeword into ue(v) or se(v) value.
// Latency : combinational.
// Backpr. : none.
// Ports   : acc (info bits with leading 1), k (order), sgn (se mode) -> val.
module exp_golomb_map
    import exp_golomb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int KW         = 2
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [KW-1:0]         k,
    input  logic                  sgn,
    output logic [DATA_WIDTH-1:0] val
);

    logic [DATA_WIDTH-1:0] one_k;
    logic [DATA_WIDTH-1:0] n;
    logic [MAP_W-1:0]      se;

    always_comb begin
        one_k = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << k;
        // acc always holds at least 2^k for a finished codeword, so no underflow.
        n     = acc - one_k;
        se    = ue_to_se(MAP_W'(n));
        val   = sgn ? se[DATA_WIDTH-1:0] : n;
    end

endmodule

// File: rtl/exp_golomb_k_decoder.sv
// Purpose : serial-in, parallel-out order-k Exp-Golomb decoder (ue/se, runtime k).
// Latency : valid_o rises the cycle after the last codeword bit is accepted.
// Backpr. : while an output waits for ready_i, ready_o is low; one bubble per codeword.
// Ports   : clk_i, rstn_i (async, active-low), dft_tm_i (masks reset), clr_i (flush),
//           k_i/signed_i (latched on first bit), bus (bit in / value out handshakes).
module exp_golomb_k_decoder
    import exp_golomb_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int K_MAX      = 3,
    localparam int KW         = (K_MAX > 0) ? $clog2(K_MAX + 1) : 1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   dft_tm_i,
    input  logic                   clr_i,
    input  logic [KW-1:0]          k_i,
    input  logic                   signed_i,
    exp_golomb_k_decoder_if.slave  bus
);

    localparam int CW = cnt_width(DATA_WIDTH);

    logic                  rstn_b_w;
    state_e                state;
    logic [CW-1:0]         zcnt;
    logic [CW-1:0]         scnt;
    logic [DATA_WIDTH-1:0] acc;
    logic [KW-1:0]         k_lat;
    logic                  sgn_lat;
    logic                  err_q;

    logic                  accept;
    logic                  first;
    logic [KW-1:0]         k_clip;
    logic [KW-1:0]         k_use;
    logic [CW-1:0]         zmax;
    logic [CW-1:0]         sum;
    logic [DATA_WIDTH-1:0] map_val;

    // Test mode holds the internal reset inactive.
    assign rstn_b_w = dft_tm_i ? 1'b1 : rstn_i;

    always_comb begin
        accept = bus.valid_i && (state != OUT) && !clr_i;
        // zcnt is zero in PREFIX only until the first bit of a codeword lands.
        first  = (state == PREFIX) && (zcnt == '0);
        k_clip = (k_i > KW'(K_MAX)) ? KW'(K_MAX) : k_i;
        // The first bit must already see its own codeword's k, not the stale latch.
        k_use  = first ? k_clip : k_lat;
        zmax   = CW'(DATA_WIDTH - 1) - CW'(k_use);
        sum    = zcnt + CW'(k_use);
    end

    always_ff @(posedge clk_i or negedge rstn_b_w) begin
        if (!rstn_b_w) begin
            state   <= PREFIX;
            zcnt    <= '0;
            scnt    <= '0;
            acc     <= '0;
            k_lat   <= '0;
            sgn_lat <= 1'b0;
            err_q   <= 1'b0;
        end else if (clr_i) begin
            state   <= PREFIX;
            zcnt    <= '0;
            scnt    <= '0;
            acc     <= '0;
            k_lat   <= '0;
            sgn_lat <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                PREFIX: begin
                    if (accept) begin
                        if (first) begin
                            k_lat   <= k_clip;
                            sgn_lat <= signed_i;
                        end
                        if (bus.dt_i) begin
                            acc   <= DATA_WIDTH'(1);
                            scnt  <= sum;
                            state <= (sum == '0) ? OUT : SUFFIX;
                        end else if (zcnt == zmax) begin
                            // One more zero could not fit the value in DATA_WIDTH bits.
                            err_q <= 1'b1;
                            state <= OUT;
                        end else begin
                            zcnt <= zcnt + CW'(1);
                        end
                    end
                end
                SUFFIX: begin
                    if (accept) begin
                        acc  <= {acc[DATA_WIDTH-2:0], bus.dt_i};
                        scnt <= scnt - CW'(1);
                        if (scnt == CW'(1)) begin
                            state <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (bus.ready_i) begin
                        state <= PREFIX;
                        zcnt  <= '0;
                        acc   <= '0;
                        err_q <= 1'b0;
                    end
                end
                default: state <= PREFIX;
            endcase
        end
    end

    exp_golomb_map #(
        .DATA_WIDTH (DATA_WIDTH),
        .KW         (KW)
    ) u_map (
        .acc (acc),
        .k   (k_lat),
        .sgn (sgn_lat),
        .val (map_val)
    );

    assign bus.valid_o = (state == OUT);
    assign bus.ready_o = (state != OUT);
    assign bus.err_o   = err_q;
    assign bus.dt_o    = ((state == OUT) && !err_q) ? map_val : '0;

endmodule

// File: tb/tb_exp_golomb_k_decoder.sv
// Purpose : self-checking bench for exp_golomb_k_decoder against an encoder-side model.
// Latency : checks valid_o the cycle after each codeword's last accepted bit.
// Backpr. : drives ready_i full-rate, randomly, and held low for fixed stretches.
module tb_exp_golomb_k_decoder;
    import exp_golomb_pkg::*;

    localparam int DW = 16;
    localparam int KM = 3;
    localparam int KW = $clog2(KM + 1);

    logic          clk_i    = 1'b0;
    logic          rstn_i   = 1'b0;
    logic          dft_tm_i = 1'b0;
    logic          clr_i    = 1'b0;
    logic [KW-1:0] k_i      = '0;
    logic          signed_i = 1'b0;

    exp_golomb_k_decoder_if #(.DATA_WIDTH(DW)) bus ();

    exp_golomb_k_decoder #(.DATA_WIDTH(DW), .K_MAX(KM)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .dft_tm_i (dft_tm_i),
        .clr_i    (clr_i),
        .k_i      (k_i),
        .signed_i (signed_i),
        .bus      (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0]   bits;   // codeword, sent from bit len-1 down to bit 0
        int            len;
        int            k;
        bit            sg;
        logic [DW-1:0] val;
        bit            err;
    } cw_t;

    cw_t           cw_q[$];
    bit            pend;
    logic [DW-1:0] exp_val;
    bit            exp_err;
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Encoder view: m = n + 2^k written in L bits, preceded by L-1-k zeros.
    function automatic cw_t mk(input int k, input bit sg, input longint n, input longint v);
        cw_t    c;
        longint m = n + (longint'(1) << k);
        int     l = 0;
        while ((m >> l) != 0) l++;
        c.bits = 64'(m);
        c.len  = 2 * l - 1 - k;
        c.k    = k;
        c.sg   = sg;
        c.val  = DW'(v);
        c.err  = 1'b0;
        return c;
    endfunction

    task automatic add_ue(input int k, input longint n);
        cw_q.push_back(mk(k, 1'b0, n, n));
    endtask

    task automatic add_se(input int k, input longint s);
        longint n = (s > 0) ? (2 * s - 1) : (-2 * s);
        cw_q.push_back(mk(k, 1'b1, n, s));
    endtask

    // DW-k zeros: one more prefix zero than a DW-bit value can carry.
    task automatic add_ovf(input int k);
        cw_t c;
        c.bits = '0;
        c.len  = DW - k;
        c.k    = k;
        c.sg   = 1'b0;
        c.val  = '0;
        c.err  = 1'b1;
        cw_q.push_back(c);
    endtask

    // mode 0: ready_i always 1 and no input gaps; 1: random gaps/backpressure;
    // 2: ready_i held low for 5 cycles of every pending output.
    task automatic run_q(input int mode);
        int  guard = 0;
        int  bp    = 0;
        int  idx   = 0;
        bit  have  = 1'b0;
        cw_t c;
        while ((cw_q.size() > 0 || have || pend) && guard < 8000) begin
            @(negedge clk_i);
            guard++;
            chk("valid_o", bus.valid_o, pend);
            chk("ready_o", bus.ready_o, !pend);
            if (pend) begin
                chk("dt_o", bus.dt_o, exp_val);
                chk("err_o", bus.err_o, exp_err);
                case (mode)
                    0:       bus.ready_i = 1'b1;
                    1:       bus.ready_i = ($urandom_range(0, 2) != 0);
                    default: bus.ready_i = (bp >= 5);
                endcase
                bp++;
                if (bus.ready_i) begin
                    pend = 1'b0;
                    bp   = 0;
                end
            end else begin
                bus.ready_i = 1'($urandom_range(0, 1));
            end
            if (!have && cw_q.size() > 0) begin
                c    = cw_q.pop_front();
                have = 1'b1;
                idx  = 0;
            end
            if (have) begin
                bus.valid_i = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.dt_i    = c.bits[c.len - 1 - idx];
                // Only the first bit's k/mode matter; scramble them afterwards.
                k_i         = (idx == 0) ? KW'(c.k) : KW'($urandom_range(0, KM));
                signed_i    = (idx == 0) ? c.sg : 1'($urandom_range(0, 1));
                if (bus.valid_i && bus.ready_o) begin
                    idx++;
                    if (idx == c.len) begin
                        have    = 1'b0;
                        pend    = 1'b1;
                        exp_val = c.val;
                        exp_err = c.err;
                    end
                end
            end else begin
                bus.valid_i = 1'b0;
            end
        end
        if (guard >= 8000) chk("run_timeout", 0, 1);
        @(negedge clk_i);
        bus.valid_i = 1'b0;
    endtask

    task automatic drive_bits(input logic [31:0] b, input int n, input int k, input bit sg);
        for (int i = n - 1; i >= 0; i--) begin
            int g    = 0;
            bit done = 1'b0;
            while (!done && g < 50) begin
                @(negedge clk_i);
                g++;
                bus.valid_i = 1'b1;
                bus.dt_i    = b[i];
                k_i         = KW'(k);
                signed_i    = sg;
                if (bus.ready_o) done = 1'b1;
            end
            if (!done) chk("drive_timeout", 0, 1);
        end
        @(negedge clk_i);
        bus.valid_i = 1'b0;
    endtask

    initial begin
        cw_t c;
        pend        = 1'b0;
        bus.valid_i = 1'b0;
        bus.dt_i    = 1'b0;
        bus.ready_i = 1'b0;

        repeat (2) @(negedge clk_i);
        chk("rst_valid_o", bus.valid_o, 0);
        chk("rst_ready_o", bus.ready_o, 1);
        chk("rst_dt_o", bus.dt_o, 0);
        chk("rst_err_o", bus.err_o, 0);
        rstn_i = 1'b1;

        // ue k=0: 1 010 00111
        add_ue(0, 0); add_ue(0, 1); add_ue(0, 6);
        run_q(0);
        // ue k=2: 100 111 01000
        add_ue(2, 0); add_ue(2, 3); add_ue(2, 4);
        run_q(0);
        // se k=0: 011 010 00101
        add_se(0, -1); add_se(0, 1); add_se(0, -2);
        run_q(0);
        // backpressure with the next codeword already offered
        add_ue(0, 5); add_ue(1, 2); add_se(3, -7);
        run_q(2);
        // largest values and prefix overflow, then normal decoding resumes
        add_ue(0, 65534); add_ovf(0); add_ue(0, 3);
        add_ovf(3); add_ue(3, 65527); add_se(0, -32767); add_se(0, 32767);
        add_ovf(1); add_se(2, 9);
        run_q(0);

        // flush mid-suffix, with a bit offered during the flush cycle
        bus.ready_i = 1'b0;
        drive_bits(32'b001, 3, 0, 1'b0);
        @(negedge clk_i);
        clr_i       = 1'b1;
        bus.valid_i = 1'b1;
        bus.dt_i    = 1'b1;
        @(negedge clk_i);
        clr_i       = 1'b0;
        bus.valid_i = 1'b0;
        chk("clr_valid_o", bus.valid_o, 0);
        chk("clr_ready_o", bus.ready_o, 1);
        add_ue(1, 5); add_ue(0, 2);
        run_q(0);

        // reset masked by test mode: codeword 00111 survives after its first 3 bits
        drive_bits(32'b001, 3, 0, 1'b0);
        dft_tm_i = 1'b1;
        rstn_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("dft_valid_o", bus.valid_o, 0);
        rstn_i   = 1'b1;
        dft_tm_i = 1'b0;
        c.bits = 64'b11; c.len = 2; c.k = 0; c.sg = 1'b0; c.val = DW'(6); c.err = 1'b0;
        cw_q.push_back(c);
        run_q(0);

        // async reset while an output is pending
        bus.ready_i = 1'b0;
        drive_bits(32'b010, 3, 0, 1'b0);
        chk("pre_rst_valid_o", bus.valid_o, 1);
        chk("pre_rst_dt_o", bus.dt_o, 1);
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_valid_o", bus.valid_o, 0);
        chk("arst_ready_o", bus.ready_o, 1);
        chk("arst_dt_o", bus.dt_o, 0);
        chk("arst_err_o", bus.err_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        add_ue(3, 11);
        run_q(0);

        // randomized mix of ue, se and overflow codewords
        for (int i = 0; i < 80; i++) begin
            int k = $urandom_range(0, KM);
            int r = $urandom_range(0, 9);
            if (r == 0) begin
                add_ovf(k);
            end else if (r < 5) begin
                int     l = $urandom_range(k + 1, DW);
                longint m = (longint'(1) << (l - 1)) |
                            (longint'($urandom) & ((longint'(1) << (l - 1)) - 1));
                add_ue(k, m - (longint'(1) << k));
            end else begin
                longint rng = longint'(1) << $urandom_range(0, 14);
                longint s   = longint'($urandom_range(0, 32'(2 * rng))) - rng;
                add_se(k, s);
            end
        end
        run_q(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exp_golomb_k_decoder.md
Name: exp_golomb_k_decoder

Overview:
Serial-in, parallel-out order-k Exp-Golomb decoder.
- Next-generation bitstream decoder: k is runtime-selectable, with optional signed (se) mapping.
- Ready/valid handshakes on both sides with output backpressure.
- Explicit overflow error reporting, synchronous flush, and back-to-back codeword decoding with no idle gap needed between codewords.

Parameters:
- DATA_WIDTH, 16, width of the decoded value and of the internal accumulator.
- K_MAX, 3, largest supported order k. Legal range 0..DATA_WIDTH-2.
- KW, $clog2(K_MAX+1), width of k_i (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; asynchronous, active-low
- dft_tm_i  in  1  test mode; when 1, rstn_i is masked (internal reset held inactive)
- clr_i  in  1  synchronous flush
- k_i  in  KW  Exp-Golomb order
- signed_i  in  1  0 = ue(v) output, 1 = se(v) output
- dt_i  in  1  serial code bit
- valid_i  in  1  dt_i valid
- ready_o  out  1  decoder accepts a bit this cycle
- dt_o  out  DATA_WIDTH  decoded value (two's complement when signed_i=1)
- err_o  out  1  qualifies the current output as an overflow error
- valid_o  out  1  output valid
- ready_i  in  1  downstream accepts the output

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on rstn_i. Internal reset = dft_tm_i ? 1 : rstn_i.
- Reset values: state=PREFIX; zcnt, scnt, acc, k_lat, sgn_lat = 0; ready_o=1; valid_o=0; err_o=0; dt_o=0.
- Bit acceptance: a bit is accepted when valid_i && ready_o. ready_o = 1 in PREFIX and SUFFIX, 0 in OUT.
- Latching k and mode: on the first accepted bit of each codeword, k_lat <= min(k_i, K_MAX) and sgn_lat <= signed_i. They are held until the codeword completes. Changes to k_i/signed_i mid-codeword are ignored.
- ZMAX = DATA_WIDTH-1-k_lat.
- State PREFIX:
  - Accepted 0 with zcnt < ZMAX: zcnt++.
  - Accepted 0 with zcnt == ZMAX: overflow. Go to OUT with err_o=1, dt_o=0.
  - Accepted 1: acc <= 1 and scnt <= zcnt+k_lat. If that sum is 0, go to OUT; otherwise go to SUFFIX.
- State SUFFIX: each accepted bit does acc <= {acc[W-2:0], dt_i} and scnt--. The bit accepted with scnt==1 moves the FSM to OUT.
- State OUT:
  - valid_o=1. dt_o and err_o are held stable until ready_i=1.
  - On the handshake: go to PREFIX, clear zcnt/acc. ready_o returns to 1 the next cycle, giving one bubble per codeword.
- Output arithmetic (computed from registered acc; dt_o=0 whenever valid_o=0):
  - n = acc - (1<<k_lat), DATA_WIDTH bits, never underflows.
  - Unsigned: dt_o = n.
  - Signed: n odd gives (n+1)>>1; n even gives -(n>>1). Always fits DATA_WIDTH signed given ZMAX.
- Latency: the last bit of a codeword is accepted in cycle N; valid_o is high in cycle N+1.
- clr_i: highest synchronous priority. Forces the reset values, discards any partial codeword and any pending output. No bit is accepted in a cycle where clr_i=1.
- Async reset mid-codeword: immediate return to reset values. Any pending output is lost.
- valid_i low in PREFIX or SUFFIX simply stalls; there is no timeout.

Decomposition:
- Package exp_golomb_pkg holds:
  - state enum {PREFIX, SUFFIX, OUT};
  - function ue_to_se(n) (signed mapping);
  - localparam helper for counter width, $clog2(DATA_WIDTH).
- One natural sub-module, exp_golomb_map: combinational n computation plus signed/unsigned mapping, also reused by the future encoder bench model.
- The FSM, counters and accumulator stay in the top module.

Test Plan:
- ue k=0, ready_i=1, bit stream 1 010 00111 -> outputs 0, 1, 6 with err_o=0. Each valid_o comes one cycle after the codeword's last bit.
- ue k=2, stream 100 111 01000 -> outputs 0, 3, 4. Changing k_i to 0 in the middle of the third codeword does not alter the result.
- se k=0, stream 011 010 00101 -> outputs -1 (0xFFFF), +1, -2 (0xFFFE).
- Backpressure: hold ready_i=0 for 5 cycles with valid_o=1 -> dt_o stable, ready_o=0, no input bit consumed. Raise ready_i -> one handshake, ready_o=1 the following cycle.
- Overflow, DATA_WIDTH=8, k=0: 7 zeros, 1, then 1111111 -> 254, no error. Then 8 zeros -> valid_o=1, err_o=1, dt_o=0, after which decoding resumes in PREFIX.
- clr_i pulse mid-suffix -> no output and the next codeword decodes correctly. rstn_i low with dft_tm_i=1 -> state is unaffected. rstn_i low with dft_tm_i=0 -> all outputs return to reset values at once.
